idct_4: RTL

Sequential 4-point inverse DCT in the block floating-point format used by the forward 4-point DCT: sign bit, 8-bit biased exponent (bias 127), 24-bit mantissa with explicit leading one in bit 23. It accepts four coefficients (y0..y3) through a valid/ready handshake and returns four reconstructed samples (x0..x3). It sits on the decode side of the image-compression path, after dequantisation and before the 2-D column/row transpose. The block uses one shared FP add/sub unit and one FP multiply-by-constant unit, time-multiplexed by an FSM.

---
 rtl/idct_4.sv | 348 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/idct_4.sv
// ----------------------------------------------------------------------------
// idct_4 : sequential 4-point inverse DCT in block floating point.
//
// Number format: {sign, 8-bit biased exponent (bias 127), 24-bit mantissa with
// an explicit leading one in bit 23}. Exponent 0 means zero.
//
// One shared add/sub unit and one multiply-by-constant unit are time-shared
// by an FSM (IDLE, S1..S9, DONE):
//    a = 0.5(y0+y2), b = 0.5(y0-y2), c = c1*y1 + c3*y3, d = c3*y1 - c1*y3
//    x0 = a+c, x1 = b+d, x2 = b-d, x3 = a-c
//
// Ports
//    clk, rst_n          clock, asynchronous active-low reset
//    in_valid/in_ready   coefficient handshake (in_ready high only in IDLE)
//    y0s..y3s, y0e..y3e, y0..y3    coefficient sign / exponent / mantissa
//    out_valid/out_ready result handshake (out_valid high only in DONE)
//    x0s..x3s, x0e..x3e, x0..x3    reconstructed samples (registered)
// ----------------------------------------------------------------------------
module idct_4 #(
   parameter logic [23:0] C1_M = 24'hA73D75,   // cos(pi/8)/sqrt2, exponent 126
   parameter logic [23:0] C3_M = 24'h8A8BD4    // sin(pi/8)/sqrt2, exponent 125
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        y0s,
   input  logic        y1s,
   input  logic        y2s,
   input  logic        y3s,
   input  logic [7:0]  y0e,
   input  logic [7:0]  y1e,
   input  logic [7:0]  y2e,
   input  logic [7:0]  y3e,
   input  logic [23:0] y0,
   input  logic [23:0] y1,
   input  logic [23:0] y2,
   input  logic [23:0] y3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        x0s,
   output logic        x1s,
   output logic        x2s,
   output logic        x3s,
   output logic [7:0]  x0e,
   output logic [7:0]  x1e,
   output logic [7:0]  x2e,
   output logic [7:0]  x3e,
   output logic [23:0] x0,
   output logic [23:0] x1,
   output logic [23:0] x2,
   output logic [23:0] x3
);

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
   } fp_t;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_S1   = 4'd1,
      ST_S2   = 4'd2,
      ST_S3   = 4'd3,
      ST_S4   = 4'd4,
      ST_S5   = 4'd5,
      ST_S6   = 4'd6,
      ST_S7   = 4'd7,
      ST_S8   = 4'd8,
      ST_S9   = 4'd9,
      ST_DONE = 4'd10
   } state_t;

   localparam logic [7:0] C1_E = 8'd126;
   localparam logic [7:0] C3_E = 8'd125;
   localparam fp_t FP_ZERO = {1'b0, 8'd0, 24'd0};

   // Final packing: flush underflow / zero mantissa to +0, saturate overflow.
   function automatic fp_t fp_pack(input logic s, input logic signed [10:0] e,
                                   input logic [23:0] m);
      fp_t r;
      if ((m == 24'd0) || (e <= 11'sd0)) begin
         r = FP_ZERO;
      end else if (e >= 11'sd255) begin
         r = {s, 8'd254, 24'hFFFFFF};
      end else begin
         r = {s, e[7:0], m};
      end
      return r;
   endfunction

   // Add/sub with truncating alignment; optional halving of the result.
   function automatic fp_t fp_add(input fp_t a, input fp_t b, input logic sub,
                                  input logic halve);
      logic [23:0]        am, bm, big_m, sml_m, sml_sh, diff, res_m;
      logic [7:0]         big_e, sml_e, shamt;
      logic               bs, big_s, sml_s, found;
      logic [24:0]        sum;
      logic [4:0]         lz;
      logic signed [10:0] res_e;
      // A zero operand contributes no magnitude, whatever its mantissa field.
      am = (a.e == 8'd0) ? 24'd0 : a.m;
      bm = (b.e == 8'd0) ? 24'd0 : b.m;
      bs = b.s ^ sub;
      if ({a.e, am} >= {b.e, bm}) begin
         big_m = am; big_e = a.e; big_s = a.s;
         sml_m = bm; sml_e = b.e; sml_s = bs;
      end else begin
         big_m = bm; big_e = b.e; big_s = bs;
         sml_m = am; sml_e = a.e; sml_s = a.s;
      end
      shamt  = big_e - sml_e;
      sml_sh = (shamt > 8'd23) ? 24'd0 : (sml_m >> shamt);
      res_e  = $signed({3'b000, big_e});
      sum    = 25'd0;
      diff   = 24'd0;
      lz     = 5'd0;
      found  = 1'b0;
      if (big_s == sml_s) begin
         sum = {1'b0, big_m} + {1'b0, sml_sh};
         if (sum[24]) begin
            res_m = sum[24:1];
            res_e = res_e + 11'sd1;
         end else begin
            res_m = sum[23:0];
         end
      end else begin
         diff = big_m - sml_sh;
         for (int i = 23; i >= 0; i--) begin
            if (!found) begin
               if (diff[i]) begin
                  found = 1'b1;
               end else begin
                  lz = lz + 5'd1;
               end
            end else begin
               found = 1'b1;
            end
         end
         res_m = diff << lz;
         res_e = res_e - $signed({6'b000000, lz});
      end
      if (halve) begin
         res_e = res_e - 11'sd1;
      end else begin
         res_e = res_e;
      end
      // Exact cancellation leaves res_m = 0, which packs as +0.
      return fp_pack(big_s, res_e, res_m);
   endfunction

   // Multiply: keep the top 24 bits of the normalised 48-bit product.
   function automatic fp_t fp_mul(input fp_t a, input fp_t b);
      logic [47:0]        prod;
      logic [23:0]        res_m;
      logic signed [10:0] res_e;
      fp_t                r;
      prod  = {24'd0, a.m} * {24'd0, b.m};
      res_e = $signed({3'b000, a.e}) + $signed({3'b000, b.e}) - 11'sd127;
      if (prod[47]) begin
         res_m = prod[47:24];
         res_e = res_e + 11'sd1;
      end else begin
         res_m = prod[46:23];
      end
      if ((a.e == 8'd0) || (b.e == 8'd0)) begin
         r = FP_ZERO;
      end else begin
         r = fp_pack(a.s ^ b.s, res_e, res_m);
      end
      return r;
   endfunction

   state_t state_r;
   logic   in_ready_r;
   logic   out_valid_r;
   fp_t    y0_r, y1_r, y2_r, y3_r;
   fp_t    a_r, b_r, c_r, d_r;
   fp_t    m1_r, m2_r, m3_r, m4_r;
   fp_t    r0_r, r1_r, r3_r;
   fp_t    x0_r, x1_r, x2_r, x3_r;

   fp_t    c1_s, c3_s;
   fp_t    add_a_s, add_b_s, add_res_s;
   fp_t    mul_a_s, mul_b_s, mul_res_s;
   logic   add_sub_s, add_halve_s;

   assign c1_s = {1'b0, C1_E, C1_M};
   assign c3_s = {1'b0, C3_E, C3_M};

   // Operand selection for the shared adder and multiplier, per FSM step.
   always_comb begin
      add_a_s     = y0_r;
      add_b_s     = y2_r;
      add_sub_s   = 1'b0;
      add_halve_s = 1'b0;
      mul_a_s     = c1_s;
      mul_b_s     = y1_r;
      case (state_r)
         ST_S1: begin
            add_halve_s = 1'b1;
            mul_a_s     = c1_s;
            mul_b_s     = y1_r;
         end
         ST_S2: begin
            add_sub_s   = 1'b1;
            add_halve_s = 1'b1;
            mul_a_s     = c3_s;
            mul_b_s     = y3_r;
         end
         ST_S3: begin
            add_a_s = m1_r;
            add_b_s = m2_r;
            mul_a_s = c3_s;
            mul_b_s = y1_r;
         end
         ST_S4: begin
            mul_a_s = c1_s;
            mul_b_s = y3_r;
         end
         ST_S5: begin
            add_a_s   = m3_r;
            add_b_s   = m4_r;
            add_sub_s = 1'b1;
         end
         ST_S6: begin
            add_a_s = a_r;
            add_b_s = c_r;
         end
         ST_S7: begin
            add_a_s   = a_r;
            add_b_s   = c_r;
            add_sub_s = 1'b1;
         end
         ST_S8: begin
            add_a_s = b_r;
            add_b_s = d_r;
         end
         ST_S9: begin
            add_a_s   = b_r;
            add_b_s   = d_r;
            add_sub_s = 1'b1;
         end
         default: begin
            add_sub_s = 1'b0;
         end
      endcase
   end

   assign add_res_s = fp_add(add_a_s, add_b_s, add_sub_s, add_halve_s);
   assign mul_res_s = fp_mul(mul_a_s, mul_b_s);

   // FSM, datapath registers and registered handshake / result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         y0_r <= FP_ZERO;  y1_r <= FP_ZERO;  y2_r <= FP_ZERO;  y3_r <= FP_ZERO;
         a_r  <= FP_ZERO;  b_r  <= FP_ZERO;  c_r  <= FP_ZERO;  d_r  <= FP_ZERO;
         m1_r <= FP_ZERO;  m2_r <= FP_ZERO;  m3_r <= FP_ZERO;  m4_r <= FP_ZERO;
         r0_r <= FP_ZERO;  r1_r <= FP_ZERO;  r3_r <= FP_ZERO;
         x0_r <= FP_ZERO;  x1_r <= FP_ZERO;  x2_r <= FP_ZERO;  x3_r <= FP_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  y0_r       <= {y0s, y0e, y0};
                  y1_r       <= {y1s, y1e, y1};
                  y2_r       <= {y2s, y2e, y2};
                  y3_r       <= {y3s, y3e, y3};
                  in_ready_r <= 1'b0;
                  state_r    <= ST_S1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_S1: begin
               a_r     <= add_res_s;
               m1_r    <= mul_res_s;
               state_r <= ST_S2;
            end
            ST_S2: begin
               b_r     <= add_res_s;
               m2_r    <= mul_res_s;
               state_r <= ST_S3;
            end
            ST_S3: begin
               c_r     <= add_res_s;
               m3_r    <= mul_res_s;
               state_r <= ST_S4;
            end
            ST_S4: begin
               m4_r    <= mul_res_s;
               state_r <= ST_S5;
            end
            ST_S5: begin
               d_r     <= add_res_s;
               state_r <= ST_S6;
            end
            ST_S6: begin
               r0_r    <= add_res_s;
               state_r <= ST_S7;
            end
            ST_S7: begin
               r3_r    <= add_res_s;
               state_r <= ST_S8;
            end
            ST_S8: begin
               r1_r    <= add_res_s;
               state_r <= ST_S9;
            end
            ST_S9: begin
               // All four results land together so x* only change on DONE entry.
               x0_r        <= r0_r;
               x1_r        <= r1_r;
               x2_r        <= add_res_s;
               x3_r        <= r3_r;
               out_valid_r <= 1'b1;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign x0s = x0_r.s;  assign x0e = x0_r.e;  assign x0 = x0_r.m;
   assign x1s = x1_r.s;  assign x1e = x1_r.e;  assign x1 = x1_r.m;
   assign x2s = x2_r.s;  assign x2e = x2_r.e;  assign x2 = x2_r.m;
   assign x3s = x3_r.s;  assign x3e = x3_r.e;  assign x3 = x3_r.m;

endmodule
